// File: rtl/hash_core_arbiter.sv
// rtl/hash_core_arbiter.sv - round-robin arbiter sharing one start/end hash core
// Grants one requester at a time, returns the captured digest, and aborts hung operations.
module hash_core_arbiter #(
    parameter int NREQ    = 4,
    parameter int DW      = 1024,
    parameter int HW      = 256,
    parameter int TIMEOUT = 4096
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req_i,
    input  logic [NREQ*DW-1:0]  msg_i,
    output logic [NREQ-1:0]     done_o,
    output logic                err_o,
    output logic [HW-1:0]       digest_o,
    output logic [NREQ-1:0]     grant_o,
    output logic                busy_o,
    output logic                core_start_o,
    output logic [DW-1:0]       core_msg_o,
    input  logic                core_end_i,
    input  logic [HW-1:0]       core_digest_i
);

    localparam int IW     = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW_RAW = $clog2(TIMEOUT + 1);
    localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [IW-1:0] LAST_IDX = IW'(NREQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_RELEASE
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   gidx_q, gidx_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            err_q, err_d;
    logic            start_q, start_d;
    logic [HW-1:0]   digest_q, digest_d;
    logic [CW-1:0]   count_q, count_d;

    logic            pick_valid;
    logic [IW-1:0]   pick_idx;
    logic [IW-1:0]   ptr_next;

    // Scan from ptr upward with wrap; the first eligible requester wins.
    always_comb begin
        int            cand;
        logic [IW-1:0] cidx;
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        cidx       = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = int'(ptr_q) + i;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            cidx = IW'(cand);
            if (!pick_valid && req_i[cidx] && !done_q[cidx]) begin
                pick_valid = 1'b1;
                pick_idx   = cidx;
            end
        end
    end

    assign ptr_next = (gidx_q == LAST_IDX) ? '0 : gidx_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gidx_d   = gidx_q;
        grant_d  = grant_q;
        done_d   = done_q;
        err_d    = err_q;
        start_d  = start_q;
        digest_d = digest_q;
        count_d  = count_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    gidx_d           = pick_idx;
                    grant_d          = '0;
                    grant_d[pick_idx] = 1'b1;
                    start_d          = 1'b1;
                    count_d          = '0;
                    state_d          = ST_RUN;
                end
            end
            ST_RUN: begin
                // A completing core wins over a watchdog expiring on the same cycle.
                if (core_end_i) begin
                    digest_d = core_digest_i;
                    done_d   = grant_q;
                    err_d    = 1'b0;
                    start_d  = 1'b0;
                    state_d  = ST_RELEASE;
                end else if ((TIMEOUT != 0) && (count_q == CNT_LAST)) begin
                    done_d   = grant_q;
                    err_d    = 1'b1;
                    start_d  = 1'b0;
                    state_d  = ST_RELEASE;
                end else begin
                    count_d  = count_q + 1'b1;
                end
            end
            ST_RELEASE: begin
                // Hold until both handshakes have fallen so the core is idle before regranting.
                if (!core_end_i && !(|(req_i & grant_q))) begin
                    done_d  = '0;
                    err_d   = 1'b0;
                    grant_d = '0;
                    ptr_d   = ptr_next;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            gidx_q   <= '0;
            grant_q  <= '0;
            done_q   <= '0;
            err_q    <= 1'b0;
            start_q  <= 1'b0;
            digest_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gidx_q   <= gidx_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            err_q    <= err_d;
            start_q  <= start_d;
            digest_q <= digest_d;
            count_q  <= count_d;
        end
    end

    // Requester 0 occupies the most significant slice of msg_i.
    always_comb begin
        core_msg_o = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant_q[k]) begin
                core_msg_o = msg_i[(NREQ-1-k)*DW +: DW];
            end
        end
    end

    assign done_o       = done_q;
    assign err_o        = err_q;
    assign digest_o     = digest_q;
    assign grant_o      = grant_q;
    assign busy_o       = (state_q != ST_IDLE);
    assign core_start_o = start_q;

endmodule

// File: tb/tb_hash_core_arbiter.sv
// tb/tb_hash_core_arbiter.sv - self-checking bench for hash_core_arbiter
module tb_hash_core_arbiter;

    localparam int NREQ    = 4;
    localparam int DW      = 64;
    localparam int HW      = 64;
    localparam int TIMEOUT = 16;

    logic                clk = 1'b0;
    logic                reset;
    logic [NREQ-1:0]     req_i;
    logic [NREQ*DW-1:0]  msg_i;
    logic [NREQ-1:0]     done_o;
    logic                err_o;
    logic [HW-1:0]       digest_o;
    logic [NREQ-1:0]     grant_o;
    logic                busy_o;
    logic                core_start_o;
    logic [DW-1:0]       core_msg_o;
    logic                core_end_i;
    logic [HW-1:0]       core_digest_i;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] msgs [NREQ];
    int          mptr;
    logic [63:0] mdig;

    typedef struct {
        int          k;
        int          lat;
        logic [63:0] dig;
        int          hold;
        logic        exp_err;
        logic [63:0] exp_dig;
    } vec_t;

    vec_t tbl [5];

    hash_core_arbiter #(
        .NREQ(NREQ), .DW(DW), .HW(HW), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_i(req_i),
        .msg_i(msg_i),
        .done_o(done_o),
        .err_o(err_o),
        .digest_o(digest_o),
        .grant_o(grant_o),
        .busy_o(busy_o),
        .core_start_o(core_start_o),
        .core_msg_o(core_msg_o),
        .core_end_i(core_end_i),
        .core_digest_i(core_digest_i)
    );

    always #5 clk = ~clk;

    assign msg_i = {msgs[0], msgs[1], msgs[2], msgs[3]};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int p);
        for (int i = 0; i < NREQ; i++) begin
            if (r[(p + i) % NREQ]) return (p + i) % NREQ;
        end
        return -1;
    endfunction

    // One complete operation for requester g: grant, core completion or watchdog, release.
    task automatic serve(input int g, input int lat, input logic [63:0] d, input int hold,
                         input logic exp_err, input logic [63:0] exp_dig);
        int         n;
        logic [3:0] oh;
        oh = 4'b0001 << g;
        n = 0;
        while (grant_o == '0 && n < 40) begin
            tick();
            n++;
        end
        chk("grant_seen", 64'(n < 40), 64'd1);
        chk("grant", 64'(grant_o), 64'(oh));
        chk("start_on", 64'(core_start_o), 64'd1);
        chk("busy_on", 64'(busy_o), 64'd1);
        chk("core_msg", core_msg_o, msgs[g]);
        if (lat >= 0) begin
            repeat (lat) tick();
            chk("done_early", 64'(done_o), 64'd0);
            core_end_i    = 1'b1;
            core_digest_i = d;
            tick();
        end else begin
            n = 0;
            while (core_start_o && n < 100) begin
                n++;
                tick();
            end
            chk("watchdog_len", 64'(n), 64'(TIMEOUT));
        end
        chk("start_off", 64'(core_start_o), 64'd0);
        chk("done", 64'(done_o), 64'(oh));
        chk("err", 64'(err_o), 64'(exp_err));
        chk("digest", digest_o, exp_dig);
        req_i[g] = 1'b0;
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_grant", 64'(grant_o), 64'(oh));
            chk("hold_done", 64'(done_o), 64'(oh));
        end
        core_end_i = 1'b0;
        tick();
        chk("rel_grant", 64'(grant_o), 64'd0);
        chk("rel_done", 64'(done_o), 64'd0);
        chk("rel_busy", 64'(busy_o), 64'd0);
        chk("rel_err", 64'(err_o), 64'd0);
        chk("digest_kept", digest_o, exp_dig);
        mptr = (g + 1) % NREQ;
        mdig = exp_dig;
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int          n;
        int          g;
        int          lat;
        int          hold;
        logic [63:0] d;
        int          fair_exp [5];

        tbl[0] = '{k: 0, lat: 5,  dig: 64'hABAB_ABAB_ABAB_ABAB, hold: 0, exp_err: 1'b0, exp_dig: 64'hABAB_ABAB_ABAB_ABAB};
        tbl[1] = '{k: 2, lat: 0,  dig: 64'h0123_4567_89AB_CDEF, hold: 1, exp_err: 1'b0, exp_dig: 64'h0123_4567_89AB_CDEF};
        tbl[2] = '{k: 1, lat: -1, dig: 64'hDEAD_BEEF_DEAD_BEEF, hold: 0, exp_err: 1'b1, exp_dig: 64'h0123_4567_89AB_CDEF};
        tbl[3] = '{k: 0, lat: 3,  dig: 64'h0000_0000_0000_0000, hold: 2, exp_err: 1'b0, exp_dig: 64'h0000_0000_0000_0000};
        tbl[4] = '{k: 3, lat: 1,  dig: 64'hFFFF_FFFF_FFFF_FFFF, hold: 0, exp_err: 1'b0, exp_dig: 64'hFFFF_FFFF_FFFF_FFFF};
        fair_exp = '{0, 2, 0, 2, 0};

        for (int i = 0; i < NREQ; i++) msgs[i] = {$urandom, $urandom};
        reset         = 1'b0;
        req_i         = '0;
        core_end_i    = 1'b0;
        core_digest_i = '0;
        mptr          = 0;
        mdig          = '0;
        repeat (3) tick();
        chk("rst_grant", 64'(grant_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_start", 64'(core_start_o), 64'd0);
        chk("rst_digest", digest_o, 64'd0);
        chk("rst_msg", core_msg_o, 64'd0);
        reset = 1'b1;

        // Contention: everyone requests at once from reset.
        req_i = 4'b1111;
        for (int i = 0; i < NREQ; i++) begin
            d = {$urandom, $urandom};
            chk("contention_model", 64'(pick(req_i, mptr)), 64'(i));
            serve(i, $urandom_range(0, 4), d, 0, 1'b0, d);
        end

        // Single-requester vectors including watchdog, digest hold and late release.
        for (int i = 0; i < 5; i++) begin
            req_i[tbl[i].k] = 1'b1;
            tick();
            chk("start_latency", 64'(core_start_o), 64'd1);
            serve(tbl[i].k, tbl[i].lat, tbl[i].dig, tbl[i].hold, tbl[i].exp_err, tbl[i].exp_dig);
        end

        // Fairness: requesters 0 and 2 re-raise immediately after each completion.
        req_i = 4'b0101;
        for (int i = 0; i < 5; i++) begin
            d = {$urandom, $urandom};
            serve(fair_exp[i], 1, d, 0, 1'b0, d);
            if (i < 3) req_i[fair_exp[i]] = 1'b1;
        end

        // Late core_end with requester 3 pending during the release wait.
        req_i = 4'b0010;
        tick();
        req_i[3] = 1'b1;
        d = {$urandom, $urandom};
        serve(1, 2, d, 3, 1'b0, d);
        d = {$urandom, $urandom};
        serve(3, 0, d, 0, 1'b0, d);

        // Randomized traffic against the round-robin model.
        for (int t = 0; t < 40; t++) begin
            req_i = req_i | 4'($urandom_range(0, 15));
            if (req_i == '0) req_i[$urandom_range(0, 3)] = 1'b1;
            g    = pick(req_i, mptr);
            lat  = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 6));
            hold = (lat < 0) ? 0 : int'($urandom_range(0, 3));
            d    = {$urandom, $urandom};
            serve(g, lat, d, hold, (lat < 0), (lat < 0) ? mdig : d);
        end

        // Reset while an operation is running.
        req_i = req_i | 4'b0001;
        n = 0;
        while (grant_o == '0 && n < 40) begin
            tick();
            n++;
        end
        chk("pre_rst_start", 64'(core_start_o), 64'd1);
        #3;
        reset      = 1'b0;
        req_i      = 4'b0100;
        core_end_i = 1'b0;
        #1;
        chk("arst_grant", 64'(grant_o), 64'd0);
        chk("arst_done", 64'(done_o), 64'd0);
        chk("arst_err", 64'(err_o), 64'd0);
        chk("arst_busy", 64'(busy_o), 64'd0);
        chk("arst_start", 64'(core_start_o), 64'd0);
        chk("arst_digest", digest_o, 64'd0);
        chk("arst_msg", core_msg_o, 64'd0);
        tick();
        reset = 1'b1;
        mptr  = 0;
        mdig  = '0;
        d = {$urandom, $urandom};
        serve(2, 1, d, 0, 1'b0, d);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
